// File: rtl/apb_arb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : apb_arb_master                                             |
// | Description : Two-requester APB master. A round-robin arbiter picks one  |
// |               of two level requests. The granted transfer then runs a   |
// |               standard IDLE -> SETUP -> ACCESS APB cycle. Completion is |
// |               signalled by a one-cycle done pulse to the granted        |
// |               requester. Read data and err are valid in that cycle.     |
// | Option      : `define APB_TIMEOUT_EN enables an ACCESS-phase watchdog.   |
// |               A transfer that gets no PREADY within TIMEOUT_CYCLES      |
// |               cycles completes with err=1 and rdata=0.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports
//   PCLK, PRESETn        : clock, synchronous active-low reset
//   req0/req1            : level requests, held until the matching done
//   rw0/rw1              : direction per requester (0 = write, 1 = read)
//   addr0/1, wdata0/1    : address and write data per requester
//   done0/done1          : one-cycle completion pulses
//   rdata, err           : read data and timeout flag, valid with done
//   PSEL, PENABLE        : APB phase controls
//   READ_WRITE           : APB direction (1 = read)
//   paddr                : APB address
//   apb_write_data       : APB write data
//   prdata, PREADY       : APB slave read data and ready
module apb_arb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       READ_WRITE,
  output logic [7:0] paddr,
  output logic [7:0] apb_write_data,
  input  logic [7:0] prdata,
  input  logic       PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;      // requester granted most recently
  logic       gnt_q, gnt_d;        // requester owning the current transfer
  logic       rw_q, rw_d;
  logic [7:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       win_w;

  // On contention the requester that was not served last wins; otherwise
  // the single active requester wins.
  assign win_w = (req0 && req1) ? ~last_q : req1;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [c_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic               err_q, err_d;
  logic               tmo_hit_w;

  // The counter holds the number of ACCESS cycles already completed. Once
  // it reaches TIMEOUT_CYCLES-1, the current cycle is the last one allowed.
  assign tmo_hit_w = (tmo_cnt_q == c_CNT_W'(TIMEOUT_CYCLES - 1));
  assign err       = err_q;
`else
  logic unused_timeout_w;
  assign unused_timeout_w = |TIMEOUT_CYCLES;
  assign err              = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    rw_d     = rw_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
`ifdef APB_TIMEOUT_EN
    err_d     = 1'b0;
    tmo_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d    = win_w;
          last_d   = win_w;
          rw_d     = win_w ? rw1    : rw0;
          paddr_d  = win_w ? addr1  : addr0;
          pwdata_d = win_w ? wdata1 : wdata0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is tested first so that a ready that coincides with the
        // timeout still completes normally.
        if (PREADY) begin
          if (rw_q) begin
            rdata_d = prdata;
          end
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          state_d = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_hit_w) begin
          rdata_d = '0;
          err_d   = 1'b1;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      rw_q     <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      rw_q     <= rw_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`endif

  // The phase controls decode directly from the state register.
  assign PSEL           = (state_q != IDLE);
  assign PENABLE        = (state_q == ACCESS);
  assign READ_WRITE     = rw_q;
  assign paddr          = paddr_q;
  assign apb_write_data = pwdata_q;
  assign rdata          = rdata_q;
  assign done0          = done0_q;
  assign done1          = done1_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_apb_arb_master                                          |
// | Description : Self-checking bench for apb_arb_master. It uses a directed |
// |               vector table, hand-written corner sequences and random     |
// |               transfers. The random transfers are checked against a      |
// |               transaction-level model.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_apb_arb_master;

  localparam int unsigned TMO = 4;

  logic       PCLK;
  logic       PRESETn;
  logic       req0, req1, rw0, rw1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       done0, done1;
  logic [7:0] rdata;
  logic       err;
  logic       PSEL, PENABLE, READ_WRITE;
  logic [7:0] paddr, apb_write_data;
  logic [7:0] prdata;
  logic       PREADY;

  int n_chk  = 0;
  int n_fail = 0;

  apb_arb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .req0           (req0),
    .req1           (req1),
    .rw0            (rw0),
    .rw1            (rw1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .done0          (done0),
    .done1          (done1),
    .rdata          (rdata),
    .err            (err),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .READ_WRITE     (READ_WRITE),
    .paddr          (paddr),
    .apb_write_data (apb_write_data),
    .prdata         (prdata),
    .PREADY         (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- APB slave: memory with programmable wait states -------
  logic [7:0] smem [256];
  int         slv_dly = 0;
  int         acc_cnt = 0;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (acc_cnt == slv_dly) begin
        PREADY = 1'b1;
        if (READ_WRITE) prdata = smem[paddr];
        else begin
          prdata = 8'hEE;
          smem[paddr] = apb_write_data;
        end
      end else begin
        PREADY = 1'b0;
        prdata = 8'hEE;
      end
      acc_cnt++;
    end else begin
      PREADY  = 1'b0;
      prdata  = 8'hEE;
      acc_cnt = 0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit       r0, r1, rw0, rw1;
    bit [7:0] a0, a1, d0, d1;
    int       dly;
    bit       drop;     // requester drops req during SETUP
    int       e_which;  // 0, 1, or -1 for "no completion"
    int       e_lat;
    bit [7:0] e_pa;
    bit       e_rw;
    bit [7:0] e_wd;
    bit [7:0] e_rd;
    bit       e_err;
  } vec_t;

  function automatic vec_t mk(bit r0, bit r1, bit w0, bit w1, bit [7:0] a0, bit [7:0] a1,
                              bit [7:0] d0, bit [7:0] d1, int dly, bit drop, int ew, int el,
                              bit [7:0] epa, bit erw, bit [7:0] ewd, bit [7:0] erd, bit eerr);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.rw0 = w0; v.rw1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.dly = dly; v.drop = drop;
    v.e_which = ew; v.e_lat = el; v.e_pa = epa; v.e_rw = erw;
    v.e_wd = ewd; v.e_rd = erd; v.e_err = eerr;
    return v;
  endfunction

  // Runs one transfer from a negedge and checks it against the vector.
  task automatic apply(input vec_t v, input string tag);
    int         which, lat;
    logic [7:0] cpa, cwd, rd;
    logic       crw, e;
    bit         stable_ok, proto_ok, pulse_ok;
    which = -1; lat = 0; cpa = '0; cwd = '0; crw = 1'b0; rd = '0; e = 1'b0;
    stable_ok = 1; proto_ok = 1; pulse_ok = 1;
    slv_dly = v.dly;
    req0 = v.r0; req1 = v.r1; rw0 = v.rw0; rw1 = v.rw1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge PCLK);
      if (done0 && done1) proto_ok = 0;
      if (done0 || done1) begin
        which = done1 ? 1 : 0;
        lat   = c;
        rd    = rdata;
        e     = err;
        if (PSEL || PENABLE) proto_ok = 0;
        req0 = 1'b0; req1 = 1'b0;
        break;
      end
      if (c == 1) begin
        if (!(PSEL && !PENABLE)) proto_ok = 0;
        cpa = paddr; crw = READ_WRITE; cwd = apb_write_data;
        if (v.drop) begin req0 = 1'b0; req1 = 1'b0; end
      end else begin
        if (!(PSEL && PENABLE)) proto_ok = 0;
        if (paddr !== cpa || READ_WRITE !== crw || apb_write_data !== cwd) stable_ok = 0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({tag, " which"}, 32'(which), 32'(v.e_which));
    chk({tag, " latency"}, 32'(lat), 32'(v.e_lat));
    chk({tag, " paddr"}, 32'(cpa), 32'(v.e_pa));
    chk({tag, " rw"}, 32'(crw), 32'(v.e_rw));
    chk({tag, " wdata"}, 32'(cwd), 32'(v.e_wd));
    chk({tag, " stable"}, 32'(stable_ok), 32'd1);
    chk({tag, " protocol"}, 32'(proto_ok), 32'd1);
    if (v.e_which >= 0) begin
      @(negedge PCLK);
      if (done0 || done1) pulse_ok = 0;
      chk({tag, " rdata"}, 32'(rd), 32'(v.e_rd));
      chk({tag, " err"}, 32'(e), 32'(v.e_err));
      chk({tag, " one-cycle done"}, 32'(pulse_ok), 32'd1);
    end
  endtask

  task automatic do_reset(input bit check);
    PRESETn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge PCLK);
    if (check) begin
      chk("rst PSEL", 32'(PSEL), 32'd0);
      chk("rst PENABLE", 32'(PENABLE), 32'd0);
      chk("rst READ_WRITE", 32'(READ_WRITE), 32'd0);
      chk("rst paddr", 32'(paddr), 32'd0);
      chk("rst wdata", 32'(apb_write_data), 32'd0);
      chk("rst rdata", 32'(rdata), 32'd0);
      chk("rst done", 32'({done0, done1}), 32'd0);
      chk("rst err", 32'(err), 32'd0);
    end
    PRESETn = 1'b1;
  endtask

  vec_t tbl [10];

  initial begin
    int         nd, lastc, idle_cnt;
    int         order [4];
    bit         reached;
    bit [7:0]   mmem [256];
    int         mlast;
    vec_t       tv;

    PRESETn = 1'b0; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    PREADY = 1'b0; prdata = 8'hEE;
    for (int k = 0; k < 256; k++) smem[k] = 8'h00;

    //            r0 r1 rw0 rw1 a0     a1     d0     d1    dly drop wh lat pa    rw wd     rd     err
    tbl[0] = mk(1, 0, 0, 0, 8'h10, 8'h00, 8'hA5, 8'h00, 0, 0, 0, 3, 8'h10, 0, 8'hA5, 8'h00, 0);
    tbl[1] = mk(0, 1, 0, 1, 8'h00, 8'h10, 8'h00, 8'h00, 0, 0, 1, 3, 8'h10, 1, 8'h00, 8'hA5, 0);
    tbl[2] = mk(0, 1, 0, 0, 8'h00, 8'h3C, 8'h00, 8'h5A, 1, 0, 1, 4, 8'h3C, 0, 8'h5A, 8'hA5, 0);
    tbl[3] = mk(1, 0, 1, 0, 8'h3C, 8'h00, 8'h77, 8'h00, 2, 0, 0, 5, 8'h3C, 1, 8'h77, 8'h5A, 0);
    tbl[4] = mk(1, 1, 0, 1, 8'h20, 8'h3C, 8'h11, 8'h22, 0, 0, 1, 3, 8'h3C, 1, 8'h22, 8'h5A, 0);
    tbl[5] = mk(0, 1, 0, 1, 8'h00, 8'h10, 8'h00, 8'h33, 3, 0, 1, 6, 8'h10, 1, 8'h33, 8'hA5, 0);
    tbl[6] = mk(1, 1, 0, 1, 8'h44, 8'h10, 8'hC3, 8'h00, 0, 0, 0, 3, 8'h44, 0, 8'hC3, 8'hA5, 0);
    tbl[7] = mk(1, 1, 1, 0, 8'h44, 8'h55, 8'h00, 8'h9E, 1, 0, 1, 4, 8'h55, 0, 8'h9E, 8'hA5, 0);
    tbl[8] = mk(1, 0, 1, 0, 8'h44, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3, 8'h44, 1, 8'h00, 8'hC3, 0);
    tbl[9] = mk(0, 1, 0, 1, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 1, 1, 4, 8'h3C, 1, 8'h00, 8'h5A, 0);

    @(negedge PCLK);
    do_reset(1);

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // ---- contention after reset: both requests held for four transfers ----
    do_reset(0);
    slv_dly = 0;
    rw0 = 1'b1; rw1 = 1'b1; addr0 = 8'h10; addr1 = 8'h3C;
    req0 = 1'b1; req1 = 1'b1;
    nd = 0; lastc = 0; idle_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge PCLK);
      chk("cont exclusive done", 32'(done0 && done1), 32'd0);
      if (done0 || done1) begin
        if (nd > 0) begin
          chk($sformatf("cont gap%0d", nd), 32'(c - lastc), 32'd3);
          chk($sformatf("cont idle%0d", nd), 32'(idle_cnt), 32'd1);
        end
        order[nd] = done1 ? 1 : 0;
        chk($sformatf("cont rdata%0d", nd), 32'(rdata), (nd % 2 == 0) ? 32'hA5 : 32'h5A);
        nd++;
        lastc = c;
        idle_cnt = 0;
        if (nd == 4) begin
          req0 = 1'b0; req1 = 1'b0;
          break;
        end
      end
      if (!PSEL) idle_cnt++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont count", 32'(nd), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("cont order%0d", k), 32'(order[k]), 32'(k % 2));
    @(negedge PCLK);

    // ---- reset during ACCESS abandons the transfer ----
    slv_dly = 50;
    rw0 = 1'b1; addr0 = 8'h10; req0 = 1'b1; req1 = 1'b0;
    reached = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        reached = 1;
        break;
      end
    end
    chk("midrst reached access", 32'(reached), 32'd1);
    PRESETn = 1'b0; req1 = 1'b1;
    @(negedge PCLK);
    chk("midrst PSEL", 32'(PSEL), 32'd0);
    chk("midrst PENABLE", 32'(PENABLE), 32'd0);
    chk("midrst done", 32'({done0, done1}), 32'd0);
    PRESETn = 1'b1; req0 = 1'b0; req1 = 1'b0;
    apply(mk(1, 1, 1, 1, 8'h3C, 8'h10, 8'h00, 8'h00, 0, 0, 0, 3, 8'h3C, 1, 8'h00, 8'h5A, 0),
          "midrst next");

    // ---- slave never responds ----
`ifdef APB_TIMEOUT_EN
    apply(mk(1, 0, 1, 0, 8'h10, 8'h00, 8'h00, 8'h00, 1000, 0, 0, 2 + TMO, 8'h10, 1, 8'h00,
             8'h00, 1), "timeout");
`else
    apply(mk(1, 0, 1, 0, 8'h10, 8'h00, 8'h00, 8'h00, 1000, 0, -1, 0, 8'h10, 1, 8'h00,
             8'h00, 0), "hang");
    chk("hang still in access", 32'(PSEL && PENABLE), 32'd1);
`endif
    do_reset(0);

    // ---- random transfers against a transaction-level model ----
    for (int k = 0; k < 256; k++) begin
      smem[k] = 8'h00;
      mmem[k] = 8'h00;
    end
    mlast = 1;
    tv.e_rd = 8'h00;
    for (int i = 0; i < 40; i++) begin
      int       sel, w;
      bit       mrw;
      bit [7:0] ma, md;
      sel     = int'($urandom_range(1, 3));
      tv.r0   = (sel % 2) == 1;
      tv.r1   = sel >= 2;
      tv.rw0  = 1'($urandom);
      tv.rw1  = 1'($urandom);
      tv.a0   = 8'($urandom_range(0, 7));
      tv.a1   = 8'($urandom_range(0, 7));
      tv.d0   = 8'($urandom);
      tv.d1   = 8'($urandom);
      tv.dly  = int'($urandom_range(0, 3));
      tv.drop = 0;
      if (tv.r0 && tv.r1) w = 1 - mlast;
      else                w = tv.r1 ? 1 : 0;
      mlast = w;
      mrw = (w == 1) ? tv.rw1 : tv.rw0;
      ma  = (w == 1) ? tv.a1  : tv.a0;
      md  = (w == 1) ? tv.d1  : tv.d0;
      if (mrw) tv.e_rd = mmem[ma];
      else     mmem[ma] = md;
      tv.e_which = w;
      tv.e_lat   = 3 + tv.dly;
      tv.e_pa    = ma;
      tv.e_rw    = mrw;
      tv.e_wd    = md;
      tv.e_err   = 1'b0;
      apply(tv, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
